// File: rtl/scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : scan_decoder_if
//  Purpose  : Control and decode signals for scan_decoder.
//  Revision : 1.0 - initial release
// ============================================================================
interface scan_decoder_if #(
    parameter int N = 3
);
    localparam int c_LINES = 1 << N;

    logic               en;
    logic [1:0]         mode;
    logic [N-1:0]       x;
    logic [0:c_LINES-1] y;
    logic [N-1:0]       idx;
    logic               wrap;

    modport master (
        output en, mode, x,
        input  y, idx, wrap
    );

    modport slave (
        input  en, mode, x,
        output y, idx, wrap
    );
endinterface
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : scan_decoder
//  Purpose  : Prescaled up/down scanning index driving a one-hot line decoder.
//  Revision : 1.0 - initial release
// ============================================================================
module scan_decoder #(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               reset,
    scan_decoder_if.slave      bus
);
    localparam int               c_LINES     = 1 << N;
    localparam int               c_CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0]  c_CNT_TERM  = c_CW'(DIV - 1);
    localparam logic [N-1:0]     c_IDX_MAX   = {N{1'b1}};
    localparam logic [1:0]       c_MODE_HOLD = 2'b00;
    localparam logic [1:0]       c_MODE_LOAD = 2'b01;

    logic [N-1:0]       r_idx;
    logic [c_CW-1:0]    r_cnt;
    logic               r_act;
    logic               r_wrap;

    logic               w_up;
    logic [N-1:0]       w_idx_step;
    logic               w_wrap_step;
    logic [0:c_LINES-1] w_y;

    // mode bit 0 selects direction while scanning: 10 up, 11 down
    assign w_up        = ~bus.mode[0];
    assign w_idx_step  = w_up ? (r_idx + N'(1)) : (r_idx - N'(1));
    assign w_wrap_step = w_up ? (r_idx == c_IDX_MAX) : (r_idx == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_act  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_act  <= bus.en;
            r_wrap <= 1'b0;
            if (bus.en) begin
                case (bus.mode)
                    c_MODE_HOLD: begin
                        r_cnt <= '0;
                    end
                    c_MODE_LOAD: begin
                        r_idx <= bus.x;
                        r_cnt <= '0;
                    end
                    default: begin
                        // prescaler is shared by both directions so a
                        // direction change never loses or repeats a step
                        if (r_cnt == c_CNT_TERM) begin
                            r_cnt  <= '0;
                            r_idx  <= w_idx_step;
                            r_wrap <= w_wrap_step;
                        end else begin
                            r_cnt <= r_cnt + c_CW'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_y = '0;
        if (r_act) begin
            w_y[r_idx] = 1'b1;
        end
    end

    generate
        if (ACTIVE_LOW != 0) begin : g_active_low
            assign bus.y = ~w_y;
        end else begin : g_active_high
            assign bus.y = w_y;
        end
    endgenerate

    assign bus.idx  = r_idx;
    assign bus.wrap = r_wrap;
endmodule
`default_nettype wire

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter N, default 3, select width; output has 2**N lines; legal range N >= 1.
REQ-002 Parameter DIV, default 4, clock cycles per scan step; legal range DIV >= 1.
REQ-003 Parameter ACTIVE_LOW, default 0; 1 inverts every y line (asserted = 0).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  enable; 0 forces all y lines inactive and freezes state.
REQ-007 mode  input  2  00 hold, 01 load, 10 scan up, 11 scan down.
REQ-008 x  input  N  direct index, sampled in load mode.
REQ-009 y  output  2**N  one-hot decode, bit order [0:2**N-1]; line k asserted when idx == k.
REQ-010 idx  output  N  current registered index.
REQ-011 wrap  output  1  one-cycle pulse on index wrap-around.

Function
REQ-012 State SHALL be idx (N bits), cnt prescaler (ceil(log2(DIV)) bits, min 1), act (1 bit), wrap (1 bit); all registered.
REQ-013 act SHALL load en every cycle, giving one cycle of latency from en to y.
REQ-014 y SHALL be a combinational function of registers only: act=1 -> exactly line idx asserted; act=0 -> all lines inactive.
REQ-015 With ACTIVE_LOW=1, y SHALL be the bitwise inverse of the ACTIVE_LOW=0 value, including the all-inactive case (all ones).
REQ-016 en=0: idx and cnt SHALL hold; wrap SHALL be 0.
REQ-017 en=1, mode=00 (hold): idx SHALL hold; cnt SHALL clear to 0; wrap SHALL be 0.
REQ-018 en=1, mode=01 (load): idx SHALL take x on the same edge; cnt SHALL clear to 0; wrap SHALL be 0; y reflects x one cycle after the sampling edge.
REQ-019 en=1, mode=1x (scan): cnt SHALL increment each cycle; when cnt == DIV-1, cnt SHALL return to 0 and idx SHALL step.
REQ-020 Scan up SHALL step idx to idx+1 modulo 2**N; scan down SHALL step idx to idx-1 modulo 2**N.
REQ-021 wrap SHALL be 1 for exactly the cycle after a step from 2**N-1 to 0 (up) or from 0 to 2**N-1 (down); otherwise 0.
REQ-022 DIV=1 SHALL step idx every enabled scan cycle; cnt stays 0.
REQ-023 Switching between scan up and scan down SHALL keep cnt, so no step is lost or duplicated.
REQ-024 Switching from a scan mode to hold or load SHALL discard the partial cnt count.
REQ-025 Only a prescaler terminal count SHALL cause a step; load never asserts wrap, even when x differs from idx.
REQ-026 No X or undefined value SHALL appear on any output after the first reset edge.

Reset
REQ-027 reset=1 at a rising edge SHALL set idx=0, cnt=0, act=0, wrap=0, which gives y all inactive (all 0, or all 1 if ACTIVE_LOW).
REQ-028 reset SHALL take priority over en and every mode, including mid-scan and mid-load.
REQ-029 On the first edge after reset deasserts, the block SHALL resume from idx=0 with a full DIV-cycle count before the first step.

Verification (N=3, DIV=4, ACTIVE_LOW=0 unless stated)
REQ-030 Reset, then en=1, mode=10 for 40 cycles -> y = 8'b1000_0000 (line 0) one cycle after en; idx advances every 4 cycles 0..7,0; wrap pulses exactly once, on the 7->0 step.
REQ-031 en=1, mode=01, x=5 for one cycle, then mode=11 -> idx=5, y line 5; then 4,3,2,1,0,7 at 4-cycle spacing; wrap pulses once, on the 0->7 step.
REQ-032 Scan up, idx=3, cnt=2, en dropped for 3 cycles -> y all 0 one cycle later; idx=3 and cnt=2 retained; idx reaches 4 two enabled cycles after en returns.
REQ-033 Mid-scan at idx=6, reset pulsed for 1 cycle -> idx=0, y all 0, wrap=0; after reset, line 0 asserts once act is set, and the next step occurs 4 cycles later.
REQ-034 ACTIVE_LOW=1, DIV=1, scan up -> y = 8'b0111_1111, then 1011_1111, and so on each cycle; wrap pulses every 8 cycles; en=0 -> y = 8'hFF.
REQ-035 Scan up at cnt=2, mode toggled to 11 for one cycle, then back to 10 -> exactly one step taken at terminal count, in the direction selected at that cycle.
